uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter GAP_CLKS, default 16, idle clocks inserted between frames (range 0..255).
REQ-002 i_CLK  in  1  single clock; all logic on its rising edge.
REQ-003 i_RST  in  1  reset, synchronous, active-high.
REQ-004 i_Req0 / i_Req1  in  1  requester k has a byte pending; held high until acked.
REQ-005 i_Byte0 / i_Byte1  in  8  byte from requester k; stable while i_Reqk high.
REQ-006 i_Last0 / i_Last1  in  1  presented byte is last of requester k's frame.
REQ-007 o_Ack0 / o_Ack1  out  1  one-cycle pulse, byte of requester k captured.
REQ-008 o_Tx_DV  out  1  one-cycle start pulse to the shared uart_tx.
REQ-009 o_Tx_Byte  out  8  byte to uart_tx; registered, held until next load.
REQ-010 i_Tx_Done  in  1  uart_tx done flag; may stay high for 2 consecutive cycles.
REQ-011 o_Grant  out  2  one-hot owner of the current frame; 00 when none.
REQ-012 o_Busy  out  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, SEND, WAIT_CLR, GAP.
REQ-014 IDLE: if any i_Reqk, pick winner round-robin, set o_Grant, go LOAD next cycle.
REQ-015 Round-robin SHALL be per frame: winner is the requester other than the last granted one when both request; the pointer updates only on frame completion.
REQ-016 After reset the last-granted pointer SHALL equal 1, so requester 0 wins the first tie.
REQ-017 LOAD: capture i_Bytek into o_Tx_Byte, pulse o_Tx_DV and o_Ackk in the same cycle, go SEND.
REQ-018 The block SHALL latch i_Lastk in LOAD as the frame-end flag.
REQ-019 SEND: wait for i_Tx_Done rising edge (prev 0, now 1); then go WAIT_CLR.
REQ-020 WAIT_CLR: wait until i_Tx_Done is 0; then go LOAD if frame-end flag is 0 and i_Reqk is high, stay in WAIT_CLR if frame-end flag is 0 and i_Reqk is low (grant held), go GAP if frame-end flag is 1.
REQ-021 o_Tx_DV SHALL never assert while i_Tx_Done is 1 or before the previous byte's done edge.
REQ-022 GAP: count GAP_CLKS cycles (8-bit counter, cleared on entry), clear o_Grant, update the pointer, then go IDLE. GAP_CLKS=0 SHALL go IDLE on the next cycle.
REQ-023 A non-granted requester SHALL never be acked mid-frame, even if its request rises first.
REQ-024 A request dropped while not granted SHALL be ignored with no ack.
REQ-025 A minimum of 2 cycles SHALL separate consecutive o_Tx_DV pulses.

Reset
REQ-026 On i_RST=1: state IDLE; o_Tx_DV, o_Ack0, o_Ack1 = 0; o_Tx_Byte = 00h; o_Grant = 00; o_Busy = 0; gap counter = 0; done-edge register = 0; pointer = 1.
REQ-027 Reset mid-frame SHALL abort the frame immediately with no further DV or Ack; requesters restart their frames.

Structure
REQ-028 State encodings (3-bit) and the GAP_CLKS default SHALL live in shared package uart_ctrl_pkg.
REQ-029 Round-robin selection SHALL be sub-module rr_arb2 (inputs req[1:0], last_grant; output one-hot grant), purely combinational.
REQ-030 uart_tx stays external; this block drives only its DV/byte inputs and reads its done output.

Verification
REQ-031 Single frame, req0 only, bytes A5h, 3Ch (last) -> two DV pulses carrying A5h then 3Ch, two Ack0, o_Grant=01 throughout, then GAP_CLKS idle cycles, then o_Busy=0.
REQ-032 Both requesters assert simultaneously after reset, 2-byte frames -> req0's frame completes fully, then req1's; no interleaving; the next tie goes to req0.
REQ-033 Model i_Tx_Done high for 2 cycles -> exactly one byte counted per done; no DV while done=1.
REQ-034 Mid-frame req0 drops for 50 cycles -> grant held at 01; req1 is not served; the frame resumes when req0 returns.
REQ-035 Assert i_RST during SEND of byte 2 of 3 -> the next cycle shows every output at its reset value; a new frame from req1 afterwards is served normally.
REQ-036 GAP_CLKS=0, back-to-back single-byte frames from req1 -> IDLE is entered in the cycle after WAIT_CLR exits, and the DV spacing is at least 2 cycles.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings
// and the default number of idle clocks inserted between frames.
package uart_ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_LOAD     = 3'd1;
   localparam state_t ST_SEND     = 3'd2;
   localparam state_t ST_WAIT_CLR = 3'd3;
   localparam state_t ST_GAP      = 3'd4;

   localparam int unsigned GAP_CLKS_DEFAULT = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector. The requester that was not granted last
// wins a tie; a lone requester always wins. Purely combinational.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // pick a one-hot winner from the request pair and the last-granted index
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one external uart_tx between two byte requesters. Ownership is
// granted per frame (round-robin), bytes are handed to the transmitter one
// at a time on its done edge, and an idle gap separates frames.
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned GAP_CLKS = GAP_CLKS_DEFAULT
) (
   input  logic       i_CLK,
   input  logic       i_RST,
   input  logic       i_Req0,
   input  logic       i_Req1,
   input  logic [7:0] i_Byte0,
   input  logic [7:0] i_Byte1,
   input  logic       i_Last0,
   input  logic       i_Last1,
   output logic       o_Ack0,
   output logic       o_Ack1,
   output logic       o_Tx_DV,
   output logic [7:0] o_Tx_Byte,
   input  logic       i_Tx_Done,
   output logic [1:0] o_Grant,
   output logic       o_Busy
);

   // GAP always lasts at least one cycle; a zero gap exits on the next cycle
   localparam logic [7:0] GAP_LAST = (GAP_CLKS == 0) ? 8'd0 : 8'(GAP_CLKS - 1);

   state_t     state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic       last_grant_q, last_grant_d;
   logic [7:0] tx_byte_q, tx_byte_d;
   logic       tx_dv_q, tx_dv_d;
   logic [1:0] ack_q, ack_d;
   logic       frame_end_q, frame_end_d;
   logic       done_prev_q, done_prev_d;
   logic [7:0] gap_cnt_q, gap_cnt_d;

   logic [1:0] rr_grant;
   logic       owner_req;
   logic       done_rise;
   logic       load_now;

   rr_arb2 u_rr_arb2 (
      .req        ({i_Req1, i_Req0}),
      .last_grant (last_grant_q),
      .grant      (rr_grant)
   );

   assign owner_req = |(grant_q & {i_Req1, i_Req0});
   assign done_rise = i_Tx_Done & ~done_prev_q;

   // next-state logic; a byte is captured, DV and Ack raised as LOAD is entered
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      tx_byte_d    = tx_byte_q;
      tx_dv_d      = 1'b0;
      ack_d        = 2'b00;
      frame_end_d  = frame_end_q;
      done_prev_d  = i_Tx_Done;
      gap_cnt_d    = gap_cnt_q;
      load_now     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if ((|rr_grant) && !i_Tx_Done) begin
               grant_d  = rr_grant;
               state_d  = ST_LOAD;
               load_now = 1'b1;
            end
         end
         ST_LOAD: begin
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (done_rise) begin
               state_d = ST_WAIT_CLR;
            end
         end
         ST_WAIT_CLR: begin
            if (!i_Tx_Done) begin
               if (frame_end_q) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = 8'd0;
               end else if (owner_req) begin
                  state_d  = ST_LOAD;
                  load_now = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d      = ST_IDLE;
               grant_d      = 2'b00;
               last_grant_d = grant_q[1];
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase

      if (load_now) begin
         tx_byte_d   = grant_d[1] ? i_Byte1 : i_Byte0;
         frame_end_d = grant_d[1] ? i_Last1 : i_Last0;
         tx_dv_d     = 1'b1;
         ack_d       = grant_d;
      end
   end

   // state registers with synchronous reset; reset abandons any frame in flight
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q      <= ST_IDLE;
         grant_q      <= 2'b00;
         last_grant_q <= 1'b1;
         tx_byte_q    <= 8'h00;
         tx_dv_q      <= 1'b0;
         ack_q        <= 2'b00;
         frame_end_q  <= 1'b0;
         done_prev_q  <= 1'b0;
         gap_cnt_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         tx_byte_q    <= tx_byte_d;
         tx_dv_q      <= tx_dv_d;
         ack_q        <= ack_d;
         frame_end_q  <= frame_end_d;
         done_prev_q  <= done_prev_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   assign o_Tx_DV   = tx_dv_q;
   assign o_Tx_Byte = tx_byte_q;
   assign o_Ack0    = ack_q[0];
   assign o_Ack1    = ack_q[1];
   assign o_Grant   = grant_q;
   assign o_Busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. A scoreboard holds the bytes
// expected on the transmitter interface in order; a monitor pops and
// compares them on every DV pulse. A second instance with a zero gap
// covers back-to-back frames.
module tb_uart_tx_arbiter;

   localparam int TXLAT = 3;
   localparam int GAPN  = 16;
   localparam int ZLAT  = 4;
   localparam int ZDONE = 2;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] owner;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1, last0, last1, txDone;
   logic [7:0] byte0, byte1;
   logic       ack0, ack1, txDv, busy;
   logic [7:0] txByte;
   logic [1:0] grant;

   logic       zReq1, zDone;
   logic [7:0] zByte1;
   logic       zAck0, zAck1, zDv, zBusy;
   logic [7:0] zByte;
   logic [1:0] zGrant;

   exp_t       sb[$];
   exp_t       popped;
   int         testCount = 0;
   int         failCount = 0;
   int         cyc = 0;
   int         lastDvCyc = -100;
   int         ack0Cnt = 0;
   int         ack1Cnt = 0;
   int         txDoneLen = 1;
   logic       doneAtEdge = 1'b0;
   logic [7:0] zExp [3];

   always #5 clk = ~clk;

   uart_tx_arbiter #(.GAP_CLKS(GAPN)) dut (
      .i_CLK(clk), .i_RST(rst),
      .i_Req0(req0), .i_Req1(req1),
      .i_Byte0(byte0), .i_Byte1(byte1),
      .i_Last0(last0), .i_Last1(last1),
      .o_Ack0(ack0), .o_Ack1(ack1),
      .o_Tx_DV(txDv), .o_Tx_Byte(txByte),
      .i_Tx_Done(txDone),
      .o_Grant(grant), .o_Busy(busy)
   );

   uart_tx_arbiter #(.GAP_CLKS(0)) dutGap0 (
      .i_CLK(clk), .i_RST(rst),
      .i_Req0(1'b0), .i_Req1(zReq1),
      .i_Byte0(8'h00), .i_Byte1(zByte1),
      .i_Last0(1'b0), .i_Last1(1'b1),
      .o_Ack0(zAck0), .o_Ack1(zAck1),
      .o_Tx_DV(zDv), .o_Tx_Byte(zByte),
      .i_Tx_Done(zDone),
      .o_Grant(zGrant), .o_Busy(zBusy)
   );

   function automatic logic [1:0] onehot(input int k);
      return (k == 0) ? 2'b01 : 2'b10;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expectByte(input logic [7:0] b, input int k);
      exp_t e;
      e.data  = b;
      e.owner = onehot(k);
      sb.push_back(e);
   endtask

   task automatic setReq(input int k, input logic r, input logic [7:0] b, input logic l);
      if (k == 0) begin
         req0 = r; byte0 = b; last0 = l;
      end else begin
         req1 = r; byte1 = b; last1 = l;
      end
   endtask

   task automatic waitAck(input int k, input int budget);
      int got;
      got = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if ((k == 0) ? ack0 : ack1) begin
            got = 1;
            break;
         end
      end
      checkOutput($sformatf("ack%0dSeen", k), got, 1);
   endtask

   // requester k sends an n-byte frame, optionally dropping its request
   // for dropLen cycles before byte dropAt while checking the grant is held
   task automatic applyStimulus(input int k, input int n, input logic [7:0] b0,
                                input logic [7:0] b1, input logic [7:0] b2,
                                input int dropAt, input int dropLen);
      logic [7:0] bs [3];
      int bad;
      bs[0] = b0; bs[1] = b1; bs[2] = b2;
      for (int i = 0; i < n; i++) begin
         if (i == dropAt) begin
            setReq(k, 1'b0, bs[i], 1'b0);
            bad = 0;
            repeat (dropLen) begin
               @(negedge clk);
               if (grant !== onehot(k)) bad++;
            end
            checkOutput("dropGrantHeld", bad, 0);
         end
         setReq(k, 1'b1, bs[i], (i == n - 1));
         waitAck(k, 400);
      end
      setReq(k, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic waitIdle(input int budget, input logic [1:0] expGrant,
                           output int busyN, output int badG);
      busyN = 0;
      badG  = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (!busy) break;
         busyN++;
         if (grant !== expGrant) badG++;
      end
      checkOutput("idleReached", busy, 0);
      checkOutput("idleGrant", grant, 2'b00);
   endtask

   task automatic rstPulse();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   always @(posedge clk) doneAtEdge <= txDone;

   // monitor: every DV must match the head of the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            if (ack0 || ack1) checkOutput("ackWithDv", txDv, 1);
            if (ack0) ack0Cnt++;
            if (ack1) ack1Cnt++;
            if (txDv) begin
               checkOutput("dvWhileDone", doneAtEdge, 0);
               checkOutput("dvSpacingOk", (cyc - lastDvCyc) >= 2, 1);
               lastDvCyc = cyc;
               checkOutput("sbHasEntry", sb.size() != 0, 1);
               if (sb.size() != 0) begin
                  popped = sb.pop_front();
                  checkOutput("txByte", txByte, popped.data);
                  checkOutput("ackOwner", {ack1, ack0}, popped.owner);
                  checkOutput("grantOwner", grant, popped.owner);
               end
            end
         end
      end
   end

   // transmitter model for the main instance
   initial begin
      txDone = 1'b0;
      forever begin
         @(negedge clk);
         if (txDv) begin
            repeat (TXLAT) @(negedge clk);
            txDone = 1'b1;
            repeat (txDoneLen) @(negedge clk);
            txDone = 1'b0;
         end
      end
   end

   // transmitter model for the zero-gap instance
   initial begin
      zDone = 1'b0;
      forever begin
         @(negedge clk);
         if (zDv) begin
            repeat (ZLAT) @(negedge clk);
            zDone = 1'b1;
            repeat (ZDONE) @(negedge clk);
            zDone = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n, bad, a0, frames, lastDv, idleCnt;
      req0 = 0; req1 = 0; byte0 = 0; byte1 = 0; last0 = 0; last1 = 0;
      zReq1 = 0; zByte1 = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("rstDv", txDv, 0);
      checkOutput("rstAck", {ack1, ack0}, 2'b00);
      checkOutput("rstByte", txByte, 8'h00);
      checkOutput("rstGrant", grant, 2'b00);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstBusyGap0", zBusy, 0);
      rst = 1'b0;
      @(negedge clk);

      // single two-byte frame from requester 0
      a0 = ack0Cnt;
      expectByte(8'hA5, 0);
      expectByte(8'h3C, 0);
      applyStimulus(0, 2, 8'hA5, 8'h3C, 8'h00, -1, 0);
      waitIdle(200, 2'b01, n, bad);
      checkOutput("frameGrantHeld", bad, 0);
      checkOutput("gapBusyCycles", n, TXLAT + 1 + GAPN);
      checkOutput("ack0Count", ack0Cnt - a0, 2);
      checkOutput("sbEmptySingle", sb.size(), 0);

      // simultaneous requests after reset: req0 first, whole frames
      rstPulse();
      expectByte(8'hB0, 0);
      expectByte(8'hB1, 0);
      expectByte(8'hB2, 1);
      expectByte(8'hB3, 1);
      fork
         applyStimulus(0, 2, 8'hB0, 8'hB1, 8'h00, -1, 0);
         applyStimulus(1, 2, 8'hB2, 8'hB3, 8'h00, -1, 0);
      join
      waitIdle(200, 2'b10, n, bad);
      checkOutput("tieFrame1GrantHeld", bad, 0);
      expectByte(8'hC1, 0);
      expectByte(8'hC2, 1);
      fork
         applyStimulus(0, 1, 8'hC1, 8'h00, 8'h00, -1, 0);
         applyStimulus(1, 1, 8'hC2, 8'h00, 8'h00, -1, 0);
      join
      waitIdle(200, 2'b10, n, bad);
      checkOutput("sbEmptyTie", sb.size(), 0);

      // done held high for two cycles
      txDoneLen = 2;
      expectByte(8'h01, 0);
      expectByte(8'h02, 0);
      expectByte(8'h03, 0);
      applyStimulus(0, 3, 8'h01, 8'h02, 8'h03, -1, 0);
      waitIdle(200, 2'b01, n, bad);
      checkOutput("longDoneBusyCycles", n, TXLAT + 2 + GAPN);
      checkOutput("sbEmptyLongDone", sb.size(), 0);
      txDoneLen = 1;

      // requester 0 pauses mid-frame while requester 1 waits
      expectByte(8'hD1, 0);
      expectByte(8'hD2, 0);
      expectByte(8'hD3, 0);
      expectByte(8'hE1, 1);
      fork
         applyStimulus(0, 3, 8'hD1, 8'hD2, 8'hD3, 1, 50);
         begin
            repeat (10) @(negedge clk);
            applyStimulus(1, 1, 8'hE1, 8'h00, 8'h00, -1, 0);
         end
      join
      waitIdle(200, 2'b10, n, bad);
      checkOutput("sbEmptyPause", sb.size(), 0);

      // reset while byte 2 of 3 is being sent
      expectByte(8'h11, 0);
      expectByte(8'h22, 0);
      setReq(0, 1'b1, 8'h11, 1'b0);
      waitAck(0, 100);
      setReq(0, 1'b1, 8'h22, 1'b0);
      waitAck(0, 100);
      @(negedge clk);
      rst = 1'b1;
      setReq(0, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      checkOutput("abortDv", txDv, 0);
      checkOutput("abortAck", {ack1, ack0}, 2'b00);
      checkOutput("abortByte", txByte, 8'h00);
      checkOutput("abortGrant", grant, 2'b00);
      checkOutput("abortBusy", busy, 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("abortNoMoreDv", sb.size(), 0);
      checkOutput("abortStaysIdle", busy, 0);
      expectByte(8'hF1, 1);
      expectByte(8'hF2, 1);
      applyStimulus(1, 2, 8'hF1, 8'hF2, 8'h00, -1, 0);
      waitIdle(200, 2'b10, n, bad);
      checkOutput("afterAbortGrantHeld", bad, 0);
      checkOutput("sbEmptyAbort", sb.size(), 0);

      // zero gap, back-to-back single-byte frames from requester 1
      zExp[0] = 8'h51; zExp[1] = 8'h52; zExp[2] = 8'h53;
      zReq1 = 1'b1;
      zByte1 = zExp[0];
      frames = 0;
      lastDv = 0;
      idleCnt = 0;
      for (int c = 0; c < 400 && frames < 3; c++) begin
         @(negedge clk);
         if (zDv) begin
            checkOutput("gap0Byte", zByte, zExp[frames]);
            checkOutput("gap0Ack", {zAck1, zAck0}, 2'b10);
            checkOutput("gap0Grant", zGrant, 2'b10);
            if (frames > 0) begin
               checkOutput("gap0DvSpacing", c - lastDv, ZLAT + ZDONE + 3);
               checkOutput("gap0IdleCycles", idleCnt, 1);
            end
            lastDv = c;
            idleCnt = 0;
            frames++;
            if (frames < 3) zByte1 = zExp[frames];
            else zReq1 = 1'b0;
         end else if (!zBusy) begin
            idleCnt++;
         end
      end
      checkOutput("gap0Frames", frames, 3);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
